// File: rtl/decode_queue_if.sv
// Handshake and decoded-bundle bus between the fetch side, the decode
// queue and the execute side.
interface decode_queue_if #(
   parameter int CNT_W = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr_word;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       alu_ctrl;
   logic             shamt_en;
   logic [2:0]       branch_ctrl;
   logic             jump_ctrl;
   logic             reg_write;
   logic [2:0]       inst_type;
   logic [4:0]       rd;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [31:0]      imm;
   logic             illegal;
   logic [CNT_W-1:0] illegal_cnt;

   modport slave (
      input  in_valid, instr_word, out_ready,
      output in_ready, out_valid, alu_ctrl, shamt_en,
      output branch_ctrl, jump_ctrl, reg_write, inst_type,
      output rd, rs1, rs2, imm, illegal, illegal_cnt
   );

   modport master (
      output in_valid, instr_word, out_ready,
      input  in_ready, out_valid, alu_ctrl, shamt_en,
      input  branch_ctrl, jump_ctrl, reg_write, inst_type,
      input  rd, rs1, rs2, imm, illegal, illegal_cnt
   );
endinterface

// File: rtl/decode_queue.sv
// RV32I(M) decoder feeding a QDEPTH-entry FIFO of decoded bundles,
// with illegal-instruction counting and synchronous flush.
module decode_queue #(
   parameter int QDEPTH   = 4,
   parameter int ENABLE_M = 0,
   parameter int CNT_W    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   decode_queue_if.slave q
);
   localparam int AW = $clog2(QDEPTH);

   typedef struct packed {
      logic [4:0]  alu;
      logic        sh;
      logic [2:0]  br;
      logic        jmp;
      logic        rw;
      logic [2:0]  ty;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        ill;
   } bndl_t;

   bndl_t            dec_d;
   bndl_t            head;
   bndl_t            mem_q [QDEPTH];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0] icnt_q, icnt_d;
   logic             full, push, pop;

   logic [31:0] w;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic        ill;

   assign w   = q.instr_word;
   assign opc = w[6:0];
   assign f3  = w[14:12];
   assign f7  = w[31:25];

   // Combinational decode of the incoming word; illegal words fall back
   // to a harmless ADD-like bundle with no register write.
   always_comb begin
      dec_d     = '0;
      dec_d.br  = 3'b010;
      dec_d.rd  = w[11:7];
      dec_d.rs1 = w[19:15];
      dec_d.rs2 = w[24:20];
      ill       = 1'b0;
      unique case (opc)
         7'b0110011: begin
            dec_d.ty = 3'd0;
            dec_d.rw = 1'b1;
            if (f7 == 7'b0000001) begin
               if (ENABLE_M != 0) dec_d.alu = {2'b10, f3};
               else               ill = 1'b1;
            end else if (f7 == 7'b0000000) begin
               dec_d.alu = {2'b00, f3};
            end else if (f7 == 7'b0100000 &&
                         (f3 == 3'b000 || f3 == 3'b101)) begin
               dec_d.alu = {2'b01, f3};
            end else begin
               ill = 1'b1;
            end
         end
         7'b0010011: begin
            dec_d.ty  = 3'd1;
            dec_d.rw  = 1'b1;
            dec_d.imm = {{20{w[31]}}, w[31:20]};
            dec_d.alu = {2'b00, f3};
            if (f3 == 3'b001) begin
               dec_d.sh = 1'b1;
               ill      = (f7 != 7'b0000000);
            end else if (f3 == 3'b101) begin
               dec_d.sh  = 1'b1;
               dec_d.alu = {1'b0, f7[5], f3};
               ill       = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
         end
         7'b0000011: begin
            dec_d.ty  = 3'd1;
            dec_d.rw  = 1'b1;
            dec_d.imm = {{20{w[31]}}, w[31:20]};
            ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         7'b0100011: begin
            dec_d.ty  = 3'd2;
            dec_d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            ill       = (f3 > 3'b010);
         end
         7'b1100011: begin
            dec_d.ty  = 3'd3;
            dec_d.alu = 5'b01000;
            dec_d.br  = f3;
            dec_d.imm = {{19{w[31]}}, w[31], w[7],
                         w[30:25], w[11:8], 1'b0};
            ill       = (f3 == 3'b010) || (f3 == 3'b011);
         end
         7'b1100111: begin
            dec_d.ty  = 3'd1;
            dec_d.rw  = 1'b1;
            dec_d.jmp = 1'b1;
            dec_d.imm = {{20{w[31]}}, w[31:20]};
         end
         7'b1101111: begin
            dec_d.ty  = 3'd5;
            dec_d.rw  = 1'b1;
            dec_d.jmp = 1'b1;
            dec_d.imm = {{11{w[31]}}, w[31], w[19:12],
                         w[20], w[30:21], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_d.ty  = 3'd4;
            dec_d.rw  = 1'b1;
            dec_d.imm = {w[31:12], 12'b0};
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         dec_d.alu = '0;
         dec_d.sh  = 1'b0;
         dec_d.br  = 3'b010;
         dec_d.jmp = 1'b0;
         dec_d.rw  = 1'b0;
         dec_d.ty  = 3'd7;
         dec_d.imm = '0;
      end
      dec_d.ill = ill;
   end

   assign full = (cnt_q == (AW+1)'(QDEPTH));
   assign push = q.in_valid && !full;
   assign pop  = (cnt_q != '0) && q.out_ready;

   // Next pointers, occupancy and saturating illegal count; flush wins.
   always_comb begin
      wp_d   = push ? wp_q + 1'b1 : wp_q;
      rp_d   = pop  ? rp_q + 1'b1 : rp_q;
      cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      icnt_d = icnt_q;
      if (push && dec_d.ill && icnt_q != '1) icnt_d = icnt_q + 1'b1;
      if (flush) begin
         wp_d   = '0;
         rp_d   = '0;
         cnt_d  = '0;
         icnt_d = icnt_q;
      end
   end

   // Queue state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
         icnt_q <= '0;
      end else begin
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         icnt_q <= icnt_d;
      end
   end

   // Bundle storage, written at the tail on an accepted push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      end else if (push && !flush) begin
         mem_q[wp_q] <= dec_d;
      end
   end

   // Head entry, or the idle bundle (no branch) when empty.
   always_comb begin
      head    = '0;
      head.br = 3'b010;
      if (cnt_q != '0) head = mem_q[rp_q];
   end

   assign q.in_ready    = !full;
   assign q.out_valid   = (cnt_q != '0);
   assign q.alu_ctrl    = head.alu;
   assign q.shamt_en    = head.sh;
   assign q.branch_ctrl = head.br;
   assign q.jump_ctrl   = head.jmp;
   assign q.reg_write   = head.rw;
   assign q.inst_type   = head.ty;
   assign q.rd          = head.rd;
   assign q.rs1         = head.rs1;
   assign q.rs2         = head.rs2;
   assign q.imm         = head.imm;
   assign q.illegal     = head.ill;
   assign q.illegal_cnt = icnt_q;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: scoreboard of expected bundles,
// reference occupancy model, and a second M-enabled narrow-counter DUT.
module tb_decode_queue;
   localparam int QD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic flush_b = 1'b0;

   always #5 clk = ~clk;

   decode_queue_if #(.CNT_W(16)) ifa ();
   decode_queue_if #(.CNT_W(2))  ifb ();

   decode_queue #(.QDEPTH(QD), .ENABLE_M(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .q(ifa)
   );
   decode_queue #(.QDEPTH(QD), .ENABLE_M(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush_b), .q(ifb)
   );

   typedef struct packed {
      logic [4:0]  alu;
      logic        sh;
      logic [2:0]  br;
      logic [2:0]  ty;
      logic        rw;
      logic        jmp;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t pend;
   int   cnt_m = 0;
   int   illc_m = 0;

   function automatic exp_t mk(
      input logic [4:0] alu, input logic sh, input logic [2:0] br,
      input logic [2:0] ty, input logic rw, input logic jmp,
      input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm, input logic ill);
      exp_t e;
      e.alu = alu; e.sh = sh; e.br = br; e.ty = ty; e.rw = rw;
      e.jmp = jmp; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      e.imm = imm; e.ill = ill;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic head_chk(input exp_t e);
      chk("alu_ctrl",    32'(ifa.alu_ctrl),    32'(e.alu));
      chk("shamt_en",    32'(ifa.shamt_en),    32'(e.sh));
      chk("branch_ctrl", 32'(ifa.branch_ctrl), 32'(e.br));
      chk("inst_type",   32'(ifa.inst_type),   32'(e.ty));
      chk("reg_write",   32'(ifa.reg_write),   32'(e.rw));
      chk("jump_ctrl",   32'(ifa.jump_ctrl),   32'(e.jmp));
      chk("rd",          32'(ifa.rd),          32'(e.rd));
      chk("rs1",         32'(ifa.rs1),         32'(e.rs1));
      chk("rs2",         32'(ifa.rs2),         32'(e.rs2));
      chk("imm",         ifa.imm,              e.imm);
      chk("illegal",     32'(ifa.illegal),     32'(e.ill));
   endtask

   task automatic put(input logic [31:0] word, input exp_t e);
      ifa.in_valid   = 1'b1;
      ifa.instr_word = word;
      pend           = e;
   endtask

   // One clock of dut_a: check handshake against the model, score any
   // pop, update the model, advance past the edge, check the counter.
   task automatic step();
      exp_t e;
      bit   pu, po;
      chk("in_ready",  32'(ifa.in_ready),  32'(cnt_m < QD));
      chk("out_valid", 32'(ifa.out_valid), 32'(cnt_m > 0));
      po = (cnt_m > 0) && ifa.out_ready && !flush;
      pu = ifa.in_valid && (cnt_m < QD) && !flush;
      if (po) begin
         e = sb.pop_front();
         head_chk(e);
      end
      if (flush) begin
         sb.delete();
         cnt_m = 0;
      end else begin
         if (pu) begin
            sb.push_back(pend);
            cnt_m++;
            if (pend.ill && illc_m != 65535) illc_m++;
         end
         if (po) cnt_m--;
      end
      @(posedge clk);
      #1;
      chk("illegal_cnt", 32'(ifa.illegal_cnt), 32'(illc_m));
   endtask

   localparam logic [31:0] W_ADD  = 32'h004A82B3;
   localparam logic [31:0] W_SUB  = 32'h404A8333;
   localparam logic [31:0] W_ADDI = 32'h20998393;
   localparam logic [31:0] W_SW   = 32'h0F56A6A3;
   localparam logic [31:0] W_BLT  = 32'h0F56C6E3;
   localparam logic [31:0] W_MUL  = 32'h02A282B3;
   localparam logic [31:0] W_SLLX = 32'h02009093;
   localparam logic [31:0] W_BAD  = 32'h0000007F;

   initial begin
      exp_t e_add, e_sub, e_addi, e_sw, e_blt, e_mulx, e_sllx;
      e_add  = mk(5'h00, 0, 3'b010, 3'd0, 1, 0, 5, 21, 4, 32'h0, 0);
      e_sub  = mk(5'h08, 0, 3'b010, 3'd0, 1, 0, 6, 21, 4, 32'h0, 0);
      e_addi = mk(5'h00, 0, 3'b010, 3'd1, 1, 0, 7, 19, 9, 32'h209, 0);
      e_sw   = mk(5'h00, 0, 3'b010, 3'd2, 0, 0, 13, 13, 21, 32'hED, 0);
      e_blt  = mk(5'h08, 0, 3'b100, 3'd3, 0, 0, 13, 13, 21, 32'h8EC, 0);
      e_mulx = mk(5'h00, 0, 3'b010, 3'd7, 0, 0, 5, 5, 10, 32'h0, 1);
      e_sllx = mk(5'h00, 0, 3'b010, 3'd7, 0, 0, 1, 1, 0, 32'h0, 1);

      ifa.in_valid = 1'b0; ifa.instr_word = '0; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b0; ifb.instr_word = '0; ifb.out_ready = 1'b0;

      // reset state
      #12;
      chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
      chk("rst_in_ready",  32'(ifa.in_ready),  32'd1);
      chk("rst_cnt",       32'(ifa.illegal_cnt), 32'd0);
      chk("rst_alu",       32'(ifa.alu_ctrl),  32'd0);
      chk("rst_branch",    32'(ifa.branch_ctrl), 32'd2);
      chk("rst_imm",       ifa.imm,            32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // add then sub, streaming
      ifa.out_ready = 1'b1;
      put(W_ADD, e_add); step();
      put(W_SUB, e_sub); step();
      ifa.in_valid = 1'b0; step(); step();

      // addi, sw, blt buffered then drained in order
      ifa.out_ready = 1'b0;
      put(W_ADDI, e_addi); step();
      put(W_SW, e_sw); step();
      put(W_BLT, e_blt); step();
      ifa.in_valid = 1'b0;
      ifa.out_ready = 1'b1;
      step(); step(); step(); step();

      // fill, refused push when full, pop in full cycle, late push
      ifa.out_ready = 1'b0;
      put(W_ADD, e_add); step();
      put(W_SUB, e_sub); step();
      put(W_ADDI, e_addi); step();
      put(W_SW, e_sw); step();
      put(W_BLT, e_blt); step();
      ifa.out_ready = 1'b1;
      step(); step();
      ifa.in_valid = 1'b0;
      step(); step(); step(); step();

      // illegal words on the M-disabled queue
      put(W_MUL, e_mulx); step();
      put(W_SLLX, e_sllx); step();
      ifa.in_valid = 1'b0; step(); step();

      // mul on the M-enabled queue
      ifb.in_valid = 1'b1; ifb.instr_word = W_MUL;
      @(posedge clk); #1;
      ifb.in_valid = 1'b0;
      chk("m_out_valid", 32'(ifb.out_valid), 32'd1);
      chk("m_alu",       32'(ifb.alu_ctrl), 32'h10);
      chk("m_type",      32'(ifb.inst_type), 32'd0);
      chk("m_reg_write", 32'(ifb.reg_write), 32'd1);
      chk("m_illegal",   32'(ifb.illegal), 32'd0);
      chk("m_cnt",       32'(ifb.illegal_cnt), 32'd0);
      ifb.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("m_drained", 32'(ifb.out_valid), 32'd0);

      // narrow counter saturates at all-ones
      ifb.in_valid = 1'b1; ifb.instr_word = W_BAD;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         chk("sat_cnt", 32'(ifb.illegal_cnt), 32'((i > 3) ? 3 : i));
      end
      ifb.in_valid = 1'b0;
      @(posedge clk); #1;
      step();

      // flush with a same-cycle illegal push
      ifa.out_ready = 1'b0;
      put(W_ADD, e_add); step();
      put(W_SUB, e_sub); step();
      put(W_ADDI, e_addi); step();
      put(W_MUL, e_mulx);
      flush = 1'b1; step();
      flush = 1'b0;
      ifa.in_valid = 1'b0;
      chk("fl_alu",    32'(ifa.alu_ctrl), 32'd0);
      step(); step();

      // async reset with a full queue, then first push after release
      put(W_ADD, e_add); step();
      put(W_SUB, e_sub); step();
      put(W_ADDI, e_addi); step();
      put(W_SW, e_sw); step();
      ifa.in_valid = 1'b0;
      chk("pre_rst_full", 32'(ifa.in_ready), 32'd0);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 32'(ifa.out_valid), 32'd0);
      chk("ar_in_ready",  32'(ifa.in_ready),  32'd1);
      chk("ar_cnt",       32'(ifa.illegal_cnt), 32'd0);
      sb.delete();
      cnt_m  = 0;
      illc_m = 0;
      #2 rst_n = 1'b1;
      ifa.out_ready = 1'b1;
      put(W_ADDI, e_addi); step();
      ifa.in_valid = 1'b0;
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, parametrised successor to the combinational RV32I control unit.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them into the control bundle, register indices and sign-extended immediate.
- Buffers decoded bundles in a QDEPTH-entry FIFO toward execute.
- Adds optional RV32M decode, illegal-instruction detection/counting and pipeline flush.

Parameters:
- QDEPTH, 4: decoded-bundle FIFO entries; power of two, >=2.
- ENABLE_M, 0: 1 = decode RV32M (opcode 0110011, funct7 0000001) as legal; 0 = flag it illegal.
- CNT_W, 16: width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; empty the queue.
- in_valid  in  1  instr_word is valid.
- in_ready  out  1  queue can accept.
- instr_word  in  32  raw instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- alu_ctrl  out  5  ALU operation of head.
- shamt_en  out  1  shift-immediate uses shamt.
- branch_ctrl  out  3  branch condition.
- jump_ctrl  out  1  JAL/JALR.
- reg_write  out  1  writes rd.
- inst_type  out  3  format code.
- rd, rs1, rs2  out  5 each  register indices.
- imm  out  32  sign-extended immediate.
- illegal  out  1  head is an illegal instruction.
- illegal_cnt  out  CNT_W  accepted illegal instructions, saturating.

Behaviour:
- Reset (rst_n low, async): queue empty, out_valid=0, in_ready=1, illegal_cnt=0. All bundle outputs read 0, except branch_ctrl=3'b010 (no branch).
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = !full, purely from the registered count. No same-cycle bypass when full: a pop in a full cycle does not admit a push.
- Latency: a word accepted at edge N is at the head with out_valid=1 after edge N if the queue was empty. Bundle outputs are always the registered head entry.
- FIFO: read/write pointers wrap modulo QDEPTH. Simultaneous push and pop when non-empty and non-full leaves count unchanged. Order is strictly FIFO.
- flush has priority over push and pop: count=0, pointers=0, any same-cycle push is discarded, illegal_cnt is unchanged.
- Decode is combinational on instr_word before the FIFO write.
- inst_type codes: 0=R, 1=I (OP-IMM, LOAD, JALR), 2=S, 3=B, 4=U (LUI, AUIPC), 5=J, 7=illegal.
- alu_ctrl for R-type: {0, funct7[5], funct3}.
- alu_ctrl for OP-IMM: {0, funct3==101 ? funct7[5] : 0, funct3}.
- alu_ctrl for M ops: {1, 1'b0, funct3}.
- alu_ctrl = 00000 (ADD) for LOAD, STORE, JAL, JALR, LUI, AUIPC and illegal. Branch = 01000 (SUB).
- shamt_en=1 only for OP-IMM with funct3 001 or 101.
- branch_ctrl = funct3 for B-type, 010 otherwise.
- jump_ctrl=1 for JAL and JALR.
- reg_write=1 for R, I, U, J; 0 for S, B and illegal.
- imm uses standard I/S/B/U/J reconstruction, sign-extended from bit 31. imm=0 for R and illegal.
- Illegal when any of the following holds:
  - unknown opcode;
  - R-type funct7 not 0000000 or 0100000, and not M-legal;
  - funct7[5] set with funct3 other than 000 or 101;
  - SLLI with imm[11:5]!=0;
  - SRLI/SRAI with imm[11:5] not 0000000 or 0100000;
  - branch funct3 010 or 011;
  - store funct3 > 010;
  - load funct3 011, 110 or 111.
- Illegal entries are still queued with illegal=1 and the safe bundle above.
- illegal_cnt increments on each accepted illegal push (not on a flushed push) and saturates at all-ones.
- Reset asserted mid-operation clears everything immediately. Outputs are valid from the first edge after deassertion.

Test Plan:
- Push 0x004A82B3 (add x5,x21,x4), out_ready=1 → next cycle out_valid=1, alu_ctrl=00000, inst_type=0, reg_write=1, rd=5, rs1=21, rs2=4, branch_ctrl=010; then sub 0x404A8333 → alu_ctrl=01000, rd=6.
- Push addi 0x20998393, sw 0x0F56A6A3 and blt 0x0F56C6E3 with out_ready=0:
  - addi: imm=0x00000209, inst_type=1.
  - sw: imm=0x000000ED, inst_type=2, reg_write=0.
  - blt: imm=0x000008EC, branch_ctrl=100, inst_type=3.
  - All drain in order once out_ready=1.
- Fill QDEPTH=4 with out_ready=0 → in_ready=0 after 4th push. A 5th in_valid is not accepted. Pop + in_valid in the full cycle → count 3, then the push is accepted the next cycle.
- mul 0x02A282B3: ENABLE_M=0 → illegal=1, inst_type=7, reg_write=0, illegal_cnt=1. ENABLE_M=1 → alu_ctrl=10000, inst_type=0, reg_write=1.
- With 3 entries queued, assert flush together with a push → out_valid=0 next cycle, in_ready=1, pushed word discarded, illegal_cnt unchanged.
- Drop rst_n asynchronously between edges with a full queue → out_valid=0 and illegal_cnt=0 immediately. After release, the first push appears one cycle later.
